// File: rtl/arb_rr.sv
// Multi-channel request arbiter onto a single downstream memory port.
// Fixed-priority or round-robin selection, abandon on request drop, optional busy timeout.
module arb_rr #(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MODE    = 1,
    parameter int TIMEOUT = 0,
    localparam int SW     = DW / 8,
    localparam int GW     = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_valid,
    output logic [NCH-1:0]    ch_ready,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    input  logic [NCH*SW-1:0] ch_wstrb,
    output logic [DW-1:0]     ch_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [SW-1:0]     mem_wstrb,
    input  logic [DW-1:0]     mem_rdata,
    output logic [GW-1:0]     grant,
    output logic              timeout
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [GW:0]   NCH_W   = (GW + 1)'(NCH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   ptr, ptr_nxt, grant_nxt, ptr_adv;
    logic [GW-1:0]   base, offset, winner;
    logic [GW:0]     win_sum;
    logic [2*NCH-1:0] rot;
    logic [CW-1:0]   busy_cnt, cnt_nxt;
    logic            timeout_nxt, sel_valid, done;

    // Rotate requests so the search always starts at bit 0, then undo the rotation.
    always_comb begin
        base   = (MODE == 0) ? '0 : ptr;
        rot    = {ch_valid, ch_valid} >> base;
        offset = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) offset = GW'(k);
        end
        win_sum = {1'b0, base} + {1'b0, offset};
        if (win_sum >= NCH_W) win_sum = win_sum - NCH_W;
        winner = win_sum[GW-1:0];
    end

    always_comb begin
        sel_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == GW'(i)) begin
                sel_valid = ch_valid[i];
                mem_addr  = ch_addr[i*AW +: AW];
                mem_wdata = ch_wdata[i*DW +: DW];
                mem_wstrb = ch_wstrb[i*SW +: SW];
            end
        end
    end

    assign mem_valid = (state == BUSY) & sel_valid;
    assign done      = mem_valid & mem_ready;
    assign ch_rdata  = mem_rdata;
    assign ptr_adv   = (grant == GW'(NCH - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        ch_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_ready[i] = done & (grant == GW'(i));
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        ptr_nxt     = ptr;
        cnt_nxt     = busy_cnt;
        timeout_nxt = timeout;
        case (state)
            IDLE: begin
                if (|ch_valid) begin
                    state_nxt = BUSY;
                    grant_nxt = winner;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (!mem_ready && busy_cnt != '1) cnt_nxt = busy_cnt + 1'b1;
                if (!sel_valid) begin
                    state_nxt = IDLE;
                end else if (mem_ready) begin
                    state_nxt = IDLE;
                    if (MODE != 0) ptr_nxt = ptr_adv;
                end else if (TIMEOUT > 0 && busy_cnt == TO_LAST) begin
                    // this is the TIMEOUT-th cycle without mem_ready
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    if (MODE != 0) ptr_nxt = ptr_adv;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= '0;
            busy_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            ptr      <= ptr_nxt;
            busy_cnt <= cnt_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_arb_rr.sv
// Directed bench for arb_rr: a round-robin instance with timeout and a fixed-priority instance,
// both three channels, driven side by side from one clock.
module tb_arb_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ch_valid, vfp;
    logic        mem_ready, rfp;
    logic [95:0] ch_addr, ch_wdata;
    logic [11:0] ch_wstrb;
    logic [31:0] mem_rdata;

    logic [2:0]  rdy_rr, rdy_fp;
    logic [31:0] rdata_rr, rdata_fp, maddr_rr, maddr_fp, mwdata_rr, mwdata_fp;
    logic [3:0]  mwstrb_rr, mwstrb_fp;
    logic        mv_rr, mv_fp, to_rr, to_fp;
    logic [1:0]  grant_rr, grant_fp;

    int total = 0;
    int bad   = 0;
    int pulses;
    logic [2:0] exp_rdy [8];
    logic [1:0] exp_g   [8];

    always #5 clk = ~clk;

    arb_rr #(.NCH(3), .AW(32), .DW(32), .MODE(1), .TIMEOUT(4)) u_rr (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(rdy_rr),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb), .ch_rdata(rdata_rr),
        .mem_valid(mv_rr), .mem_ready(mem_ready), .mem_addr(maddr_rr), .mem_wdata(mwdata_rr),
        .mem_wstrb(mwstrb_rr), .mem_rdata(mem_rdata), .grant(grant_rr), .timeout(to_rr)
    );

    arb_rr #(.NCH(3), .AW(32), .DW(32), .MODE(0), .TIMEOUT(0)) u_fp (
        .clk(clk), .rst(rst), .ch_valid(vfp), .ch_ready(rdy_fp),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb), .ch_rdata(rdata_fp),
        .mem_valid(mv_fp), .mem_ready(rfp), .mem_addr(maddr_fp), .mem_wdata(mwdata_fp),
        .mem_wstrb(mwstrb_fp), .mem_rdata(mem_rdata), .grant(grant_fp), .timeout(to_fp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock cycle: drive inputs just after the edge, outputs settle before checks
    task automatic cyc(input logic [2:0] v, input logic r, input logic [2:0] vf, input logic rf);
        @(posedge clk);
        #1;
        ch_valid  = v;
        mem_ready = r;
        vfp       = vf;
        rfp       = rf;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        ch_valid  = '0;
        mem_ready = 1'b0;
        vfp       = '0;
        rfp       = 1'b0;
        ch_addr   = {32'h0000_CCC0, 32'h0000_0100, 32'h0000_AAA0};
        ch_wdata  = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
        ch_wstrb  = {4'hF, 4'b0011, 4'hC};
        mem_rdata = 32'h0;
        exp_rdy   = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        exp_g     = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};

        #12;
        chk("rst_mvalid", 64'(mv_rr), 64'h0);
        chk("rst_grant", 64'(grant_rr), 64'h0);
        chk("rst_ready", 64'(rdy_rr), 64'h0);
        chk("rst_timeout", 64'(to_rr), 64'h0);
        chk("rst_fp_mvalid", 64'(mv_fp), 64'h0);
        #10;
        rst = 1'b0;

        // all channels requesting, memory always ready
        for (int n = 0; n < 8; n++) begin
            cyc(3'b111, 1'b1, 3'b110, 1'b1);
            chk("rr_grant", 64'(grant_rr), 64'(exp_g[n]));
            chk("rr_ready", 64'(rdy_rr), 64'(exp_rdy[n]));
            chk("rr_mvalid", 64'(mv_rr), 64'(n % 2));
            chk("fp_grant", 64'(grant_fp), (n == 0) ? 64'h0 : 64'h1);
            chk("fp_ready", 64'(rdy_fp), (n % 2 == 1) ? 64'h2 : 64'h0);
            if (n % 2 == 1) begin
                chk("fp_addr", 64'(maddr_fp), 64'h100);
                chk("fp_wdata", 64'(mwdata_fp), 64'hDEAD_BEEF);
                chk("fp_wstrb", 64'(mwstrb_fp), 64'h3);
            end
        end
        cyc(3'b000, 1'b0, 3'b000, 1'b0);
        chk("rr_idle_ready", 64'(rdy_rr), 64'h0);
        chk("fp_timeout", 64'(to_fp), 64'h0);

        // channel 1 write, memory answers on the third busy cycle
        mem_rdata = 32'h1234_5678;
        pulses = 0;
        cyc(3'b010, 1'b0, 3'b000, 1'b0);
        chk("w_idle_mvalid", 64'(mv_rr), 64'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(3'b010, (k == 2), 3'b000, 1'b0);
            chk("w_mvalid", 64'(mv_rr), 64'h1);
            chk("w_grant", 64'(grant_rr), 64'h1);
            chk("w_addr", 64'(maddr_rr), 64'h100);
            chk("w_wdata", 64'(mwdata_rr), 64'hDEAD_BEEF);
            chk("w_wstrb", 64'(mwstrb_rr), 64'h3);
            chk("w_other_ready", 64'({rdy_rr[2], rdy_rr[0]}), 64'h0);
            if (rdy_rr[1]) pulses++;
        end
        cyc(3'b000, 1'b0, 3'b000, 1'b0);
        if (rdy_rr[1]) pulses++;
        chk("w_pulses", 64'(pulses), 64'h1);
        chk("w_rdata", 64'(rdata_rr), 64'h1234_5678);
        chk("fp_rdata", 64'(rdata_fp), 64'h1234_5678);
        chk("w_timeout", 64'(to_rr), 64'h0);

        // memory never ready: timeout after four busy cycles, next channel follows
        cyc(3'b011, 1'b0, 3'b000, 1'b0);
        chk("to_idle_mvalid", 64'(mv_rr), 64'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(3'b011, 1'b0, 3'b000, 1'b0);
            chk("to_mvalid", 64'(mv_rr), 64'h1);
            chk("to_grant", 64'(grant_rr), 64'h0);
            chk("to_ready", 64'(rdy_rr), 64'h0);
            chk("to_flag_early", 64'(to_rr), 64'h0);
        end
        cyc(3'b011, 1'b0, 3'b000, 1'b0);
        chk("to_flag", 64'(to_rr), 64'h1);
        chk("to_back_idle", 64'(mv_rr), 64'h0);
        chk("to_no_ready", 64'(rdy_rr), 64'h0);
        cyc(3'b011, 1'b1, 3'b000, 1'b0);
        chk("to_next_grant", 64'(grant_rr), 64'h1);
        chk("to_next_ready", 64'(rdy_rr), 64'h2);
        cyc(3'b000, 1'b0, 3'b000, 1'b0);
        chk("to_sticky", 64'(to_rr), 64'h1);

        // granted channel withdraws mid-transaction
        cyc(3'b100, 1'b0, 3'b000, 1'b0);
        cyc(3'b100, 1'b0, 3'b000, 1'b0);
        chk("ab_mvalid", 64'(mv_rr), 64'h1);
        chk("ab_grant", 64'(grant_rr), 64'h2);
        cyc(3'b000, 1'b0, 3'b000, 1'b0);
        chk("ab_drop_mvalid", 64'(mv_rr), 64'h0);
        chk("ab_drop_ready", 64'(rdy_rr), 64'h0);
        cyc(3'b101, 1'b0, 3'b000, 1'b0);
        chk("ab_idle", 64'(mv_rr), 64'h0);
        cyc(3'b101, 1'b1, 3'b000, 1'b0);
        chk("ab_ptr_kept", 64'(grant_rr), 64'h2);
        chk("ab_ready", 64'(rdy_rr), 64'h4);
        cyc(3'b000, 1'b0, 3'b000, 1'b0);

        // asynchronous reset in the middle of a busy transaction
        cyc(3'b010, 1'b0, 3'b000, 1'b0);
        cyc(3'b010, 1'b0, 3'b000, 1'b0);
        chk("rb_mvalid", 64'(mv_rr), 64'h1);
        chk("rb_grant", 64'(grant_rr), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rb_async_mvalid", 64'(mv_rr), 64'h0);
        chk("rb_async_grant", 64'(grant_rr), 64'h0);
        chk("rb_async_timeout", 64'(to_rr), 64'h0);
        mem_ready = 1'b1;
        #1;
        chk("rb_async_ready", 64'(rdy_rr), 64'h0);
        @(posedge clk);
        #1;
        chk("rb_held_ready", 64'(rdy_rr), 64'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("rb_release_mvalid", 64'(mv_rr), 64'h0);
        cyc(3'b010, 1'b1, 3'b000, 1'b0);
        chk("rb_first_grant", 64'(grant_rr), 64'h1);
        chk("rb_first_ready", 64'(rdy_rr), 64'h2);
        cyc(3'b000, 1'b0, 3'b000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
